// File: rtl/demux_registrado_8bits_pkg.sv
// Shared constants and types for the 1-to-8 registered byte demultiplexer.
// Imported by the interface, the channel register and the top level.
package demux_registrado_8bits_pkg;

    localparam int NUM_CANAIS = 8;
    localparam int SEL_W = 3;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_canal_t;

    function automatic logic [NUM_CANAIS-1:0] decodifica_sel(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_CANAIS-1:0] m;
        m = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/demux_registrado_8bits_if.sv
// Producer-side request port plus the eight consumer channels.
// master drives requests and consumer readiness; slave is the demux.
interface demux_registrado_8bits_if
    import demux_registrado_8bits_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0]      E;
    logic [SEL_W-1:0]      Sel;
    logic                  Bcast;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      D0;
    logic [WIDTH-1:0]      D1;
    logic [WIDTH-1:0]      D2;
    logic [WIDTH-1:0]      D3;
    logic [WIDTH-1:0]      D4;
    logic [WIDTH-1:0]      D5;
    logic [WIDTH-1:0]      D6;
    logic [WIDTH-1:0]      D7;
    logic [NUM_CANAIS-1:0] out_valid;
    logic [NUM_CANAIS-1:0] out_ready;
    logic [7:0]            drop_cnt;

    modport master (
        output E, Sel, Bcast, in_valid, out_ready,
        input  in_ready, D0, D1, D2, D3, D4, D5, D6, D7,
        input  out_valid, drop_cnt
    );

    modport slave (
        input  E, Sel, Bcast, in_valid, out_ready,
        output in_ready, D0, D1, D2, D3, D4, D5, D6, D7,
        output out_valid, drop_cnt
    );

endinterface

// File: rtl/canal_demux_reg.sv
// One output channel: a data register with a one-entry valid state.
// A load wins over a drain, so a byte taken this cycle is replaced in place.
module canal_demux_reg
    import demux_registrado_8bits_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             pronto,
    input  logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] d,
    output logic             valido,
    output logic             livre
);

    estado_canal_t estado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= VAZIO;
            d      <= '0;
        end else if (load) begin
            estado <= CHEIO;
            d      <= e;
        end else if (estado == CHEIO && pronto) begin
            estado <= VAZIO;
        end
    end

    assign valido = (estado == CHEIO);
    // Free also while the consumer drains this cycle (pass-through).
    assign livre  = (estado == VAZIO) || pronto;

endmodule

// File: rtl/demux_registrado_8bits.sv
// 1-to-8 registered byte demultiplexer with broadcast and stall counter.
// in_ready is the only combinational output; it never looks at in_valid.
module demux_registrado_8bits
    import demux_registrado_8bits_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    demux_registrado_8bits_if.slave bus
);

    logic [NUM_CANAIS-1:0] livre;
    logic [NUM_CANAIS-1:0] valido;
    logic [NUM_CANAIS-1:0] alvo;
    logic [NUM_CANAIS-1:0] load;
    logic [WIDTH-1:0]      d [NUM_CANAIS];
    logic                  pronto_in;
    logic                  aceita;
    logic                  stall;
    logic [7:0]            drop_cnt;

    always_comb begin
        alvo      = '0;
        pronto_in = 1'b0;
        unique case (1'b1)
            bus.Bcast: begin
                alvo      = '1;
                pronto_in = &livre;
            end
            default: begin
                alvo      = decodifica_sel(bus.Sel);
                pronto_in = livre[bus.Sel];
            end
        endcase
    end

    assign aceita = bus.in_valid & pronto_in;
    assign stall  = bus.in_valid & ~pronto_in;
    assign load   = alvo & {NUM_CANAIS{aceita}};

    for (genvar k = 0; k < NUM_CANAIS; k++) begin : g_canal
        canal_demux_reg #(
            .WIDTH (WIDTH)
        ) u_canal (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[k]),
            .pronto (bus.out_ready[k]),
            .e      (bus.E),
            .d      (d[k]),
            .valido (valido[k]),
            .livre  (livre[k])
        );
    end

    // Saturates so a long stall can never look like a short one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (stall && drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = pronto_in;
    assign bus.out_valid = valido;
    assign bus.drop_cnt  = drop_cnt;
    assign bus.D0 = d[0];
    assign bus.D1 = d[1];
    assign bus.D2 = d[2];
    assign bus.D3 = d[3];
    assign bus.D4 = d[4];
    assign bus.D5 = d[5];
    assign bus.D6 = d[6];
    assign bus.D7 = d[7];

endmodule

// File: tb/tb_demux_registrado_8bits.sv
// Directed plan plus held-request random traffic for the byte demux.
// Expected values come from a per-channel byte/flag model in the bench.
module tb_demux_registrado_8bits;
    import demux_registrado_8bits_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_registrado_8bits_if #(.WIDTH(8)) bus ();

    demux_registrado_8bits #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_ok  = 0;

    logic [7:0] md [8];
    logic [7:0] mv;
    int         mdrop;
    bit         pend;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] dut_d(input int k);
        case (k)
            0: return bus.D0;
            1: return bus.D1;
            2: return bus.D2;
            3: return bus.D3;
            4: return bus.D4;
            5: return bus.D5;
            6: return bus.D6;
            default: return bus.D7;
        endcase
    endfunction

    // A channel can take a byte if empty or emptied by its consumer now.
    function automatic bit m_ready();
        bit all_free;
        all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (mv[k] && !bus.out_ready[k]) all_free = 1'b0;
        if (bus.Bcast) return all_free;
        return !mv[bus.Sel] || bus.out_ready[bus.Sel];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) md[k] = 8'h00;
        mv    = 8'h00;
        mdrop = 0;
        pend  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_ready()));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mv));
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(mdrop));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s.D%0d", tag, k), 32'(dut_d(k)), 32'(md[k]));
    endtask

    task automatic drive(input logic [7:0] e, input logic [2:0] sel,
                         input logic bc, input logic iv,
                         input logic [7:0] ordy);
        bus.E         = e;
        bus.Sel       = sel;
        bus.Bcast     = bc;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
    endtask

    // Called just after a negedge with inputs set; ends at the next negedge.
    task automatic cyc(input string tag);
        bit r;
        bit acc;
        #1;
        check_all(tag);
        r   = m_ready();
        acc = bus.in_valid && r;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (acc && (bus.Bcast || int'(bus.Sel) == k)) begin
                md[k] = bus.E;
                mv[k] = 1'b1;
            end else if (mv[k] && bus.out_ready[k]) begin
                mv[k] = 1'b0;
            end
        end
        if (bus.in_valid && !r && mdrop < 255) mdrop++;
        pend = bus.in_valid && !r;
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #2;
        check_all("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        drive(8'hA5, 3'd3, 1'b0, 1'b1, 8'h00);
        cyc("route.req");
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("route.D3", 32'(bus.D3), 32'h00A5);
        chk("route.ov", 32'(bus.out_valid), 32'h0008);
        cyc("route.out");

        drive(8'h5A, 3'd3, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp.in_ready", 32'(bus.in_ready), 32'h0);
            cyc("bp.stall");
        end
        chk("bp.drop4", 32'(bus.drop_cnt), 32'd4);
        drive(8'h5A, 3'd3, 1'b0, 1'b1, 8'h08);
        #1;
        chk("bp.accept", 32'(bus.in_ready), 32'h1);
        cyc("bp.drain");
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("bp.D3", 32'(bus.D3), 32'h005A);
        cyc("bp.out");

        drive(8'h11, 3'd3, 1'b0, 1'b1, 8'h08);
        cyc("dl.pre");
        drive(8'h22, 3'd3, 1'b0, 1'b1, 8'h08);
        #1;
        chk("dl.seen", 32'(bus.D3), 32'h0011);
        chk("dl.in_ready", 32'(bus.in_ready), 32'h1);
        cyc("dl.req");
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("dl.D3", 32'(bus.D3), 32'h0022);
        cyc("dl.out");

        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'hFF);
        cyc("bc.clear");
        drive(8'hC3, 3'd5, 1'b1, 1'b1, 8'h00);
        cyc("bc.req");
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("bc.ov", 32'(bus.out_valid), 32'h00FF);
        chk("bc.D7", 32'(bus.D7), 32'h00C3);
        cyc("bc.out");
        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'hFF);
        cyc("bc.clear2");
        drive(8'h66, 3'd6, 1'b0, 1'b1, 8'h00);
        cyc("bc.busy6");
        drive(8'h99, 3'd0, 1'b1, 1'b1, 8'h00);
        cyc("bc.blocked");
        #1;
        chk("bc.blk_ov", 32'(bus.out_valid), 32'h0040);

        for (int i = 0; i < 300; i++) cyc("sat");
        chk("sat.drop", 32'(bus.drop_cnt), 32'd255);

        for (int i = 0; i < 2000; i++) begin
            if (!pend) begin
                bus.E        = 8'($urandom);
                bus.Sel      = 3'($urandom_range(0, 7));
                bus.Bcast    = ($urandom_range(0, 7) == 0);
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 8'($urandom);
            cyc("rnd");
        end

        drive(8'h00, 3'd0, 1'b0, 1'b0, 8'hFF);
        cyc("mr.clear");
        drive(8'h42, 3'd2, 1'b0, 1'b1, 8'h00);
        cyc("mr.ld2");
        drive(8'h55, 3'd5, 1'b0, 1'b1, 8'h00);
        cyc("mr.ld5");
        drive(8'h77, 3'd1, 1'b0, 1'b1, 8'h00);
        #1;
        chk("mr.ov", 32'(bus.out_valid), 32'h0024);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mr.ov0", 32'(bus.out_valid), 32'h0);
        chk("mr.drop0", 32'(bus.drop_cnt), 32'h0);
        chk("mr.D2", 32'(bus.D2), 32'h0);
        chk("mr.D5", 32'(bus.D5), 32'h0);
        check_all("mr.async");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            if (!pend) begin
                bus.E        = 8'($urandom);
                bus.Sel      = 3'($urandom_range(0, 7));
                bus.Bcast    = ($urandom_range(0, 5) == 0);
                bus.in_valid = ($urandom_range(0, 1) != 0);
            end
            bus.out_ready = 8'($urandom);
            cyc("rnd2");
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/demux_registrado_8bits.md
Name: demux_registrado_8bits

Overview:
- 1-to-8 registered demultiplexer for 8-bit buses; the write/distribution counterpart of the 8:1 byte read-select mux.
- Accepts one byte per cycle on a valid/ready input port and routes it to one of 8 output channels selected by a 3-bit index, or to all 8 channels in broadcast mode.
- Each output channel holds its byte in a one-entry register with its own valid/ready handshake.
- Sits between a single producer (datapath/control) and 8 consumers (register slots, display digits, peripherals).

Parameters:
WIDTH, 8, data width of the input bus and of each output channel.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
E  in  WIDTH  input data byte.
Sel  in  3  destination channel index, 0..7.
Bcast  in  1  1 = write E to all 8 channels; Sel is ignored.
in_valid  in  1  producer presents E/Sel/Bcast.
in_ready  out  1  block can accept the current request this cycle.
D0..D7  out  WIDTH each  channel data registers.
out_valid  out  8  bit k = Dk holds an unconsumed byte.
out_ready  in  8  bit k = consumer k takes Dk this cycle.
drop_cnt  out  8  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous): D0..D7 = 0, out_valid = 0, drop_cnt = 0. in_ready follows its equation, so it reads 1 during reset. Any in-flight byte is discarded. Release is synchronous to clk.
- Channel k is free when out_valid[k]=0 or out_ready[k]=1. The second case is a pass-through drain in the same cycle.
- in_ready, combinational:
  - Bcast=0: in_ready = free[Sel].
  - Bcast=1: in_ready = AND of free[0..7].
- in_ready must not depend on in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - Each targeted channel loads Dk <= E and sets out_valid[k] <= 1.
  - Latency: 1 cycle; data is visible on Dk the cycle after acceptance.
- Drain: out_valid[k] & out_ready[k] with no load to k clears out_valid[k]. Dk holds its last value; it is not cleared.
- Drain and load on the same channel in the same cycle: Dk takes the new byte and out_valid[k] stays 1. Every byte is delivered exactly once.
- Non-targeted channels are unaffected by any accept.
- Broadcast is all-or-nothing. If any channel is busy, in_ready=0 and no channel is written.
- Stall: in_valid=1 and in_ready=0 increments drop_cnt by 1, saturating at 255. The producer must hold E/Sel/Bcast stable until accepted. The block does not latch the request on a stall.
- Sel and Bcast are don't-care when in_valid=0.
- No FSM beyond the per-channel valid bit (states VAZIO/CHEIO): VAZIO->CHEIO on load; CHEIO->VAZIO on drain without load; CHEIO->CHEIO on drain with load.
- All outputs except in_ready are registered.

Decomposition:
- Shared package holds: NUM_CANAIS=8, SEL_W=3, DROP_MAX=8'hFF.
- One sub-module, canal_demux_reg (one WIDTH-bit register + valid bit + free logic), instantiated 8 times.
- The top level keeps Sel decode, broadcast AND, in_ready and drop_cnt.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with out_valid=8'h24. Required: out_valid=0, D0..D7=0, drop_cnt=0 immediately, before any clk edge.
- Single route: E=8'hA5, Sel=3, in_valid=1 for one cycle, all out_ready=0. Next cycle: D3=8'hA5, out_valid=8'h08, other Dk=0.
- Back-pressure: channel 3 full, out_ready[3]=0; request E=8'h5A, Sel=3 held 4 cycles. Required: in_ready=0 and drop_cnt=4. Then raise out_ready[3]: accepted the same cycle, and the next cycle D3=8'h5A, out_valid[3]=1.
- Simultaneous drain+load: D3=8'h11 valid, out_ready[3]=1, in E=8'h22, Sel=3. Required: in_ready=1, the consumer sees 8'h11, next cycle D3=8'h22 with out_valid[3]=1.
- Broadcast: Bcast=1, E=8'hC3, all channels empty. Next cycle D0..D7=8'hC3 and out_valid=8'hFF. Repeat with channel 6 busy: in_ready=0, no channel changes, drop_cnt increments.
- Saturation: hold a stalled request for 300 cycles. Required: drop_cnt stops at 255 and never wraps to 0.
